// File: rtl/display_scan.sv
// Multiplexed 7-segment scanner: prescaled digit rotation, shadowed data, guard-banded anodes.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.

// One digit's anode driver: low only when this digit is selected, outside the guard, and not blanked.
module display_scan_digit (
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    input  logic lit,
    input  logic blank,
    output logic an
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) an <= 1'b1;
        else        an <= ~(sel && lit && !blank);
    end
endmodule

module display_scan #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] datos,
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic [3:0]            Ver,
    output logic [N_DIGITS-1:0]   anodos,
    output logic                  dp_n
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [CW-1:0]              cnt;
    logic [IW-1:0]              idx;
    logic [N_DIGITS-1:0][3:0]   sh_nib;
    logic [N_DIGITS-1:0]        sh_dp;
    logic                       tick;
    logic                       lit;
    logic [N_DIGITS-1:0]        blank;

    assign tick = enable && (cnt == CW'(REFRESH_DIV - 1));
    // Anodes stay dark for the first GUARD cycles of a slot so the previous digit's segments settle.
    assign lit  = enable && (cnt >= CW'(GUARD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick)
                idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_nib <= '0;
            sh_dp  <= '0;
        end else if (load) begin
            sh_nib <= datos;
            sh_dp  <= dp_in;
        end
    end

    // Ver keeps tracking the shadow even when stopped or guarded; only anodes/dp are gated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ver  <= 4'h0;
            dp_n <= 1'b1;
        end else begin
            Ver  <= sh_nib[idx];
            dp_n <= enable ? ~sh_dp[idx] : 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // tz[k]: digits k..N_DIGITS-1 all hold nibble 0 with no decimal point.
    logic [N_DIGITS-1:1] tz;
    assign blank[0] = 1'b0;
    for (genvar k = N_DIGITS - 1; k >= 1; k--) begin : g_tz
        if (k == N_DIGITS - 1) begin : g_top
            assign tz[k] = (sh_nib[k] == 4'h0) && !sh_dp[k];
        end else begin : g_mid
            assign tz[k] = (sh_nib[k] == 4'h0) && !sh_dp[k] && tz[k+1];
        end
        assign blank[k] = tz[k];
    end
`else
    assign blank = '0;
`endif

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
        display_scan_digit u_dig (
            .clk   (clk),
            .rst_n (rst_n),
            .sel   (idx == IW'(k)),
            .lit   (lit),
            .blank (blank[k]),
            .an    (anodos[k])
        );
    end
endmodule
